// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a req/gnt/rvalid data-memory bus
//
// Accepts one load/store at a time, rejects misaligned accesses with an
// address-error code, otherwise drives a single bus beat and returns the
// extended load data (or a bus-timeout code) on a one-cycle response strobe.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   req_*            command handshake from execute (valid/ready, we, op, addr, wdata, pc)
//   bus_*            memory bus: req/we/addr/be/wdata out, gnt/rvalid/rdata in
//   resp_*           completion strobe with extended load data, exception code, pc

module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] resp_pc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_B  = 3'd1;
    localparam logic [2:0] OP_H  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd3;
    localparam logic [2:0] OP_HU = 3'd4;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_TMO  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BUS_REQ, S_WAIT_R, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_pc;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_res_rdata;
    logic [1:0]  r_res_exc;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;
    logic [2:0]  w_op;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign req_ready = (r_state == S_IDLE) && reset;
    assign w_accept  = req_valid && req_ready;
    // Compared with >= so a grant landing on the last budgeted cycle still
    // leaves WAIT_R bounded instead of counting on past the limit.
    assign w_timeout = (r_cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = w_misaligned ? S_RESP : S_BUS_REQ;
            S_BUS_REQ: if (bus_gnt) w_next = S_WAIT_R;
                       else if (w_timeout) w_next = S_RESP;
            S_WAIT_R:  if (bus_rvalid || w_timeout) w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Request-side lane decode: op 5-7 fold onto word.
    always_comb begin
        w_op         = (req_op > OP_HU) ? OP_W : req_op;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = req_wdata;
        case (w_op)
            OP_B, OP_BU: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                w_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{req_wdata[15:0]}};
                w_misaligned = req_addr[0];
            end
            default: w_misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    // Response-side lane extraction from the returned word.
    always_comb begin
        w_byte = bus_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_op)
            OP_B:    w_load = {{24{w_byte[7]}}, w_byte};
            OP_BU:   w_load = {24'd0, w_byte};
            OP_H:    w_load = {{16{w_half[15]}}, w_half};
            OP_HU:   w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_exc    <= '0;
            resp_pc     <= '0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_op        <= '0;
            r_addr_lo   <= '0;
            r_pc        <= '0;
            r_res_rdata <= '0;
            r_res_exc   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we      <= req_we;
                    r_op      <= w_op;
                    r_addr_lo <= req_addr[1:0];
                    r_pc      <= req_pc;
                    r_cnt     <= '0;
                    if (w_misaligned) begin
                        r_res_exc   <= req_we ? EXC_ADES : EXC_ADEL;
                        r_res_rdata <= '0;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                    end
                end
                S_BUS_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                    end else if (w_timeout) begin
                        bus_req     <= 1'b0;
                        r_res_exc   <= EXC_TMO;
                        r_res_rdata <= '0;
                    end
                end
                S_WAIT_R: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus_rvalid) begin
                        r_res_exc   <= EXC_NONE;
                        r_res_rdata <= r_we ? 32'd0 : w_load;
                    end else if (w_timeout) begin
                        r_res_exc   <= EXC_TMO;
                        r_res_rdata <= '0;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= r_res_rdata;
                    resp_exc   <= r_res_exc;
                    resp_pc    <= r_pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store command at a time from the execute stage over a valid/ready handshake.
- Checks alignment, builds byte-lane enables and replicated write data, and drives a req/gnt/rvalid memory bus.
- Returns sign- or zero-extended load data, or an exception code, on a one-cycle response strobe.
- Sits between the multi-cycle CPU's execute stage and a wait-stated data memory.

Parameters:
- TIMEOUT, 255: bus cycles allowed from entering BUS_REQ until completion before a bus-timeout exception.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- req_valid  input  1  command valid.
- req_ready  output  1  unit can accept a command.
- req_we  input  1  1=store, 0=load.
- req_op  input  3  0=W, 1=B, 2=H, 3=BU, 4=HU; 5-7 treated as W.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bits are used for B/H.
- req_pc  input  32  PC of the instruction, carried to the response.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write.
- bus_addr  output  32  word address; {addr[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_gnt  input  1  request accepted by memory.
- bus_rvalid  input  1  read data valid, or write acknowledge.
- bus_rdata  input  32  read word.
- resp_valid  output  1  one-cycle completion strobe.
- resp_rdata  output  32  extended load data; 0 for stores and exceptions.
- resp_exc  output  2  0=none, 1=AdEL, 2=AdES, 3=bus timeout.
- resp_pc  output  32  latched req_pc.

Behaviour:
- States: IDLE, BUS_REQ, WAIT_R, RESP.
- req_ready = (state==IDLE) && reset; this is combinational. All other outputs are registered.
- Reset (reset==0 at edge): state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, resp_valid, resp_rdata, resp_exc, resp_pc, timeout counter all 0.
  - Reset mid-transaction abandons the operation: no response, and bus_req is low from the next cycle.
- Accept on an edge with req_valid && req_ready. Latch we, op, addr, wdata and pc.
- Misalignment:
  - Misaligned means W with addr[1:0]!=0, or H/HU with addr[0]!=0.
  - A misaligned command goes to RESP with resp_exc = 1 for a load or 2 for a store.
  - No bus transaction is issued.
- Aligned command -> BUS_REQ. bus_req=1, and all bus fields are held stable until gnt.
- Byte enables and write data:
  - W: be=4'b1111, wdata unchanged.
  - H: be = addr[1] ? 4'b1100 : 4'b0011; wdata={2{wdata[15:0]}}.
  - B/BU: be = 4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Loads drive the same be pattern with bus_we=0.
- BUS_REQ -> WAIT_R on the edge where bus_gnt=1. bus_req drops in the same transition.
- WAIT_R -> RESP on the edge where bus_rvalid=1.
  - rvalid is sampled only in WAIT_R; rvalid in any other state is ignored.
- Load extraction from bus_rdata:
  - W: whole word.
  - H: rdata[16*addr[1]+:16], sign-extended; HU zero-extended.
  - B: rdata[8*addr[1:0]+:8], sign-extended; BU zero-extended.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_* hold their values until the next response.
- Timeout:
  - Counter clears on entry to BUS_REQ and increments each cycle in BUS_REQ/WAIT_R.
  - If count==TIMEOUT-1 at an edge without the completing gnt/rvalid, go to RESP with exc=3 and resp_rdata=0.
  - Completion on that same edge wins over timeout.
- Latency with a zero-wait bus (gnt in first BUS_REQ cycle, rvalid next cycle):
  - Accept at edge N, resp_valid high in the cycle after edge N+3.
  - Misaligned: resp_valid in the cycle after edge N+1.
  - Maximum throughput: one operation per 4 cycles.

Test Plan:
- Reset: hold reset=0 two cycles with req_valid=1 -> req_ready=0, bus_req=0, resp_valid=0; after release req_ready=1.
- Load: LB addr=0x0000_0013 with rdata=0x80FF_1234 -> bus_addr=0x10, be=4'b1000, resp_rdata=0xFFFF_FF80.
  - Same access as LBU -> resp_rdata=0x0000_0080.
- Store: SH addr=0x22, wdata=0xDEAD_BEEF -> bus_we=1, be=4'b1100, bus_wdata=0xBEEF_BEEF.
  - Response after rvalid: exc=0, rdata=0.
- Misaligned: LW addr=0x6 -> no bus_req, resp_exc=1 one cycle after accept; SH addr=0x5 -> resp_exc=2.
- Wait states: gnt delayed 3 cycles, rvalid delayed 2 more, bus fields stable throughout.
  - Spurious rvalid while in BUS_REQ -> ignored; LW 0x40 returns rvalid-cycle data.
- Timeout and reset abort:
  - TIMEOUT=8, gnt never asserted -> resp_exc=3 after 8 BUS_REQ cycles.
  - reset=0 during WAIT_R -> no resp_valid; next command completes normally.
